// File: rtl/enum_state_recorder.sv
// enum_state_recorder: samples a 2-bit enumerated state bus and logs every
//   transition as {old, new, dwell} into a small record FIFO drained over
//   valid/ready.
// Latency: a record formed at clock edge N is presented (rec_valid=1) in cycle N+1.
// Backpressure: rec_ready low stalls the head with rec_data held stable; when the
//   FIFO is full and nothing pops, new records are dropped and counted.
//
// Ports:
//   clk, rst          - rising-edge clock, synchronous active-high reset
//   state/state_valid - producer enum value and its qualifier
//   rec_valid/rec_ready/rec_data - record output {old[1:0], new[1:0], dwell}
//   fill              - current FIFO occupancy
//   illegal_seen      - sticky, a value >= NUM_STATES was sampled
//   overflow          - sticky, at least one record was dropped
//   drop_count        - saturating count of dropped records
module enum_state_recorder #(
  parameter int NUM_STATES = 4,
  parameter int CNT_W      = 8,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [1:0]               state,
  input  logic                     state_valid,
  output logic                     rec_valid,
  input  logic                     rec_ready,
  output logic [4+CNT_W-1:0]       rec_data,
  output logic [$clog2(DEPTH):0]   fill,
  output logic                     illegal_seen,
  output logic                     overflow,
  output logic [7:0]               drop_count
);

  localparam int AW    = $clog2(DEPTH);
  localparam int REC_W = 4 + CNT_W;

  localparam logic [CNT_W-1:0] DWELL_ONE = 1;
  localparam logic [CNT_W-1:0] DWELL_MAX = '1;
  localparam logic [AW-1:0]    PTR_ONE   = 1;
  localparam logic [AW:0]      FILL_ONE  = 1;
  localparam logic [AW:0]      FILL_FULL = DEPTH;

  // Tracking state
  logic             primed_q, primed_d;
  logic [1:0]       prev_q, prev_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;

  // FIFO state
  logic [REC_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      fill_q, fill_d;

  // Status
  logic             illegal_q, illegal_d;
  logic             overflow_q, overflow_d;
  logic [7:0]       drop_cnt_q, drop_cnt_d;

  // Datapath strobes
  logic             change;
  logic             sample_illegal;
  logic             pop;
  logic             full;
  logic             push_ok;
  logic             drop;
  logic [REC_W-1:0] rec_new;

  always_comb begin
    // A transition is only meaningful once a reference state has been captured.
    change         = state_valid && primed_q && (state != prev_q);
    sample_illegal = state_valid && (32'(state) >= NUM_STATES);
    rec_new        = {prev_q, state, dwell_q};

    pop     = (fill_q != '0) && rec_ready;
    full    = (fill_q == FILL_FULL);
    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    push_ok = change && (!full || pop);
    drop    = change && full && !pop;

    primed_d = primed_q;
    prev_d   = prev_q;
    dwell_d  = dwell_q;
    if (state_valid) begin
      if (!primed_q) begin
        primed_d = 1'b1;
        prev_d   = state;
        dwell_d  = DWELL_ONE;
      end else if (state == prev_q) begin
        if (dwell_q != DWELL_MAX) begin
          dwell_d = dwell_q + DWELL_ONE;
        end
      end else begin
        prev_d  = state;
        dwell_d = DWELL_ONE;
      end
    end

    fill_d = fill_q;
    case ({push_ok, pop})
      2'b10:   fill_d = fill_q + FILL_ONE;
      2'b01:   fill_d = fill_q - FILL_ONE;
      default: fill_d = fill_q;
    endcase

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    wr_ptr_d = push_ok ? (wr_ptr_q + PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop     ? (rd_ptr_q + PTR_ONE) : rd_ptr_q;

    illegal_d  = illegal_q | sample_illegal;
    overflow_d = overflow_q | drop;
    drop_cnt_d = drop_cnt_q;
    if (drop && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      primed_q   <= 1'b0;
      prev_q     <= 2'd0;
      dwell_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      fill_q     <= '0;
      illegal_q  <= 1'b0;
      overflow_q <= 1'b0;
      drop_cnt_q <= 8'd0;
    end else begin
      primed_q   <= primed_d;
      prev_q     <= prev_d;
      dwell_q    <= dwell_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      fill_q     <= fill_d;
      illegal_q  <= illegal_d;
      overflow_q <= overflow_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  // Storage is not reset; rec_data is masked while the FIFO is empty instead.
  always_ff @(posedge clk) begin
    if (!rst && push_ok) begin
      mem_q[wr_ptr_q] <= rec_new;
    end
  end

  assign rec_valid    = (fill_q != '0);
  assign rec_data     = rec_valid ? mem_q[rd_ptr_q] : '0;
  assign fill         = fill_q;
  assign illegal_seen = illegal_q;
  assign overflow     = overflow_q;
  assign drop_count   = drop_cnt_q;

endmodule

// File: tb/tb_enum_state_recorder.sv
module tb_enum_state_recorder;

  localparam logic [1:0] A = 2'd0, B = 2'd1, C = 2'd2, D = 2'd3;

  logic        clk = 1'b0;
  logic        rst, state_valid, rec_ready;
  logic [1:0]  state;

  // NUM_STATES=4 instance
  logic        rv, ill, ovf;
  logic [11:0] rd;
  logic [2:0]  fl;
  logic [7:0]  dc;
  // NUM_STATES=3 instance (same stimulus)
  logic        rv3, ill3, ovf3;
  logic [11:0] rd3;
  logic [2:0]  fl3;
  logic [7:0]  dc3;

  int errors = 0;
  int checks = 0;

  // Reference model: a queue of records plus the current run being timed.
  bit          m_primed;
  logic [1:0]  m_prev;
  int          m_dwell;
  logic [11:0] m_q[$];
  bit          m_ovf, m_ill3;
  int          m_drops;

  enum_state_recorder #(.NUM_STATES(4), .CNT_W(8), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .state(state), .state_valid(state_valid),
    .rec_valid(rv), .rec_ready(rec_ready), .rec_data(rd), .fill(fl),
    .illegal_seen(ill), .overflow(ovf), .drop_count(dc));

  enum_state_recorder #(.NUM_STATES(3), .CNT_W(8), .DEPTH(4)) dut3 (
    .clk(clk), .rst(rst), .state(state), .state_valid(state_valid),
    .rec_valid(rv3), .rec_ready(rec_ready), .rec_data(rd3), .fill(fl3),
    .illegal_seen(ill3), .overflow(ovf3), .drop_count(dc3));

  always #5 clk = ~clk;

  // Apply this cycle's inputs to the model (as the DUT will at the coming edge).
  task automatic model_step();
    bit          push;
    logic [11:0] rec;
    push = 1'b0;
    rec  = '0;
    if (rst) begin
      m_primed = 0; m_prev = 0; m_dwell = 0; m_q.delete();
      m_ovf = 0; m_ill3 = 0; m_drops = 0;
      return;
    end
    if (rec_ready && m_q.size() > 0) void'(m_q.pop_front());
    if (state_valid) begin
      if (int'(state) >= 3) m_ill3 = 1;
      if (!m_primed) begin
        m_primed = 1; m_prev = state; m_dwell = 1;
      end else if (state == m_prev) begin
        m_dwell = (m_dwell < 255) ? m_dwell + 1 : 255;
      end else begin
        rec = {m_prev, state, 8'(m_dwell)};
        push = 1'b1;
        m_prev = state;
        m_dwell = 1;
      end
    end
    if (push) begin
      if (m_q.size() < 4) m_q.push_back(rec);
      else begin
        m_ovf = 1;
        if (m_drops < 255) m_drops++;
      end
    end
  endtask

  task automatic cyc();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset();
    rst = 1; state_valid = 0; state = A;
    cyc();
    rst = 0;
  endtask

  task automatic drive(input logic [1:0] s);
    state_valid = 1; state = s;
    cyc();
  endtask

  task automatic test_reset();
    rec_ready = 1;
    apply_reset();
    checks++; if (rv !== 1'b0)  begin errors++; $display("FAIL reset_rec_valid got=%0b want=0", rv); end
    checks++; if (rd !== 12'h0) begin errors++; $display("FAIL reset_rec_data got=%h want=000", rd); end
    checks++; if (fl !== 3'd0)  begin errors++; $display("FAIL reset_fill got=%0d want=0", fl); end
    checks++; if ({ill, ovf, dc} !== 10'd0) begin errors++; $display("FAIL reset_flags got ill=%0b ovf=%0b dc=%0d want all 0", ill, ovf, dc); end
    checks++; if (ill3 !== 1'b0) begin errors++; $display("FAIL reset_illegal3 got=%0b want=0", ill3); end
  endtask

  task automatic test_basic();
    rec_ready = 1;
    apply_reset();
    drive(A); drive(A); drive(A);
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL basic_no_early_rec got=%0b want=0", rv); end
    drive(B);
    checks++; if (rv !== 1'b1 || rd !== 12'h103) begin errors++; $display("FAIL basic_rec1 got v=%0b d=%h want v=1 d=103", rv, rd); end
    drive(B);
    checks++; if (rv !== 1'b0) begin errors++; $display("FAIL basic_popped got=%0b want=0", rv); end
    drive(C);
    checks++; if (rv !== 1'b1 || rd !== 12'h602) begin errors++; $display("FAIL basic_rec2 got v=%0b d=%h want v=1 d=602", rv, rd); end
  endtask

  task automatic test_saturate();
    rec_ready = 1;
    apply_reset();
    for (int i = 0; i < 300; i++) begin
      state_valid = !(i >= 100 && i < 110);
      state = state_valid ? A : B;
      cyc();
    end
    drive(B);
    checks++; if (rd !== 12'h1FF || fl !== 3'd1) begin errors++; $display("FAIL sat_dwell got d=%h fill=%0d want d=1ff fill=1", rd, fl); end
    apply_reset();
    for (int i = 0; i < 120; i++) begin
      state_valid = (i % 6) != 3;   // 100 valid, 20 invalid
      state = state_valid ? A : C;
      cyc();
    end
    drive(B);
    checks++; if (rd !== 12'h164) begin errors++; $display("FAIL gap_dwell got d=%h want d=164", rd); end
  endtask

  task automatic test_overflow();
    logic [11:0] exp_rec [4];
    exp_rec[0] = 12'h101; exp_rec[1] = 12'h401; exp_rec[2] = 12'h101; exp_rec[3] = 12'h401;
    rec_ready = 0;
    apply_reset();
    for (int i = 0; i < 7; i++) drive((i % 2) ? B : A);
    checks++; if (fl !== 3'd4 || ovf !== 1'b1 || dc !== 8'd2) begin errors++; $display("FAIL ovf_state got fill=%0d ovf=%0b dc=%0d want 4 1 2", fl, ovf, dc); end
    state_valid = 0;
    for (int i = 0; i < 3; i++) begin
      cyc();
      checks++; if (rd !== 12'h101 || rv !== 1'b1) begin errors++; $display("FAIL stall_stable got v=%0b d=%h want v=1 d=101", rv, rd); end
    end
    rec_ready = 1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (rd !== exp_rec[i]) begin errors++; $display("FAIL drain_%0d got=%h want=%h", i, rd, exp_rec[i]); end
      cyc();
    end
    checks++; if (fl !== 3'd0 || rv !== 1'b0) begin errors++; $display("FAIL drain_empty got fill=%0d v=%0b want 0 0", fl, rv); end
    checks++; if (ovf !== 1'b1 || dc !== 8'd2) begin errors++; $display("FAIL ovf_sticky got ovf=%0b dc=%0d want 1 2", ovf, dc); end
  endtask

  task automatic test_drop_sat();
    rec_ready = 0;
    apply_reset();
    for (int i = 0; i < 270; i++) drive((i % 2) ? B : A);
    checks++; if (dc !== 8'd255 || fl !== 3'd4) begin errors++; $display("FAIL drop_sat got dc=%0d fill=%0d want 255 4", dc, fl); end
  endtask

  task automatic test_full_pop();
    rec_ready = 0;
    apply_reset();
    for (int i = 0; i < 5; i++) drive((i % 2) ? B : A);
    checks++; if (fl !== 3'd4) begin errors++; $display("FAIL fullpop_fill got=%0d want=4", fl); end
    rec_ready = 1;
    drive(B);
    rec_ready = 0;
    checks++; if (fl !== 3'd4 || ovf !== 1'b0 || dc !== 8'd0) begin errors++; $display("FAIL fullpop_nodrop got fill=%0d ovf=%0b dc=%0d want 4 0 0", fl, ovf, dc); end
    checks++; if (rd !== 12'h401) begin errors++; $display("FAIL fullpop_head got=%h want=401", rd); end
  endtask

  task automatic test_illegal();
    rec_ready = 1;
    apply_reset();
    drive(A); drive(A); drive(D);
    checks++; if (ill3 !== 1'b1 || rd3 !== 12'h302) begin errors++; $display("FAIL illegal_set got ill=%0b d=%h want 1 302", ill3, rd3); end
    checks++; if (ill !== 1'b0) begin errors++; $display("FAIL illegal_n4 got=%0b want=0", ill); end
    drive(B);
    checks++; if (rd3 !== 12'hD01) begin errors++; $display("FAIL illegal_rec2 got=%h want=d01", rd3); end
    drive(B); drive(C);
    checks++; if (ill3 !== 1'b1) begin errors++; $display("FAIL illegal_sticky got=%0b want=1", ill3); end
  endtask

  task automatic test_reset_mid();
    rec_ready = 0;
    apply_reset();
    drive(A); drive(B); drive(A);
    checks++; if (fl !== 3'd2) begin errors++; $display("FAIL mid_prefill got=%0d want=2", fl); end
    rst = 1; state_valid = 1; state = B;
    cyc();
    rst = 0;
    checks++; if (fl !== 3'd0 || rv !== 1'b0) begin errors++; $display("FAIL mid_cleared got fill=%0d v=%0b want 0 0", fl, rv); end
    drive(C);
    checks++; if (fl !== 3'd0) begin errors++; $display("FAIL mid_reprime got fill=%0d want=0", fl); end
    drive(D);
    checks++; if (fl !== 3'd1 || rd !== 12'hB01) begin errors++; $display("FAIL mid_first_rec got fill=%0d d=%h want 1 b01", fl, rd); end
  endtask

  task automatic test_random();
    logic [11:0] exp_d;
    rec_ready = 1;
    apply_reset();
    for (int i = 0; i < 800; i++) begin
      rst         = ($urandom_range(99) == 0);
      state_valid = ($urandom_range(9) < 8);
      if ($urandom_range(2) == 0) state = 2'($urandom_range(3));
      rec_ready   = $urandom_range(1) == 1;
      cyc();
      exp_d = (m_q.size() > 0) ? m_q[0] : 12'h0;
      checks++;
      if ({rv, rd, fl} !== {m_q.size() > 0, exp_d, 3'(m_q.size())}) begin
        errors++; $display("FAIL rand_fifo cyc=%0d got v=%0b d=%h fill=%0d want v=%0b d=%h fill=%0d", i, rv, rd, fl, m_q.size() > 0, exp_d, m_q.size());
      end
      checks++;
      if ({ovf, dc, ill} !== {m_ovf, 8'(m_drops), 1'b0}) begin
        errors++; $display("FAIL rand_flags cyc=%0d got ovf=%0b dc=%0d ill=%0b want %0b %0d 0", i, ovf, dc, ill, m_ovf, m_drops);
      end
      checks++;
      if ({rv3, rd3, fl3, ovf3, dc3, ill3} !== {m_q.size() > 0, exp_d, 3'(m_q.size()), m_ovf, 8'(m_drops), m_ill3}) begin
        errors++; $display("FAIL rand_n3 cyc=%0d got d=%h fill=%0d ovf=%0b dc=%0d ill=%0b want d=%h fill=%0d ovf=%0b dc=%0d ill=%0b",
                           i, rd3, fl3, ovf3, dc3, ill3, exp_d, m_q.size(), m_ovf, m_drops, m_ill3);
      end
    end
  endtask

  initial begin
    rst = 1; state_valid = 0; state = A; rec_ready = 0;
    test_reset();
    test_basic();
    test_saturate();
    test_overflow();
    test_drop_sat();
    test_full_pop();
    test_illegal();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/enum_state_recorder.md
Name: enum_state_recorder

Overview:
- Sink end of the enumerated-state interface: samples a 2-bit enum state bus driven by a producer (one interface instance) and records every state transition.
- Each record carries {old state, new state, dwell cycles} and is pushed into an internal FIFO. A downstream trace/log consumer drains the FIFO over a valid/ready port.
- Used alongside the VAL_A..VAL_D style enums, including 3-value enums whose fourth encoding is illegal.

Parameters:
- NUM_STATES, 4, number of legal encodings (2..4); values >= NUM_STATES are illegal.
- CNT_W, 8, dwell counter width (>= 2).
- DEPTH, 4, record FIFO depth (power of 2, >= 2).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  synchronous reset, active-high.
- state  in  2  enum state value from producer.
- state_valid  in  1  state is meaningful this cycle.
- rec_valid  out  1  FIFO head record available.
- rec_ready  in  1  consumer accepts head record.
- rec_data  out  4+CNT_W  {old[1:0], new[1:0], dwell[CNT_W-1:0]}; old occupies the MSBs.
- fill  out  $clog2(DEPTH)+1  current FIFO occupancy.
- illegal_seen  out  1  sticky; set when an illegal value is sampled.
- overflow  out  1  sticky; set when a record is dropped.
- drop_count  out  8  saturating count of dropped records.

Behaviour:
- Reset (rst high at a clk edge), cycle after:
  - rec_valid=0, rec_data=0, fill=0.
  - illegal_seen=0, overflow=0, drop_count=0.
  - primed=0, prev=0, dwell=0.
  - FIFO pointers are zeroed; any queued records are discarded.
  - rst has priority over all other activity in the same cycle.
- Sampling occurs only on cycles with state_valid=1. When state_valid=0: no compare, no count, prev is held.
- First valid sample after reset (primed=0):
  - prev<=state, dwell<=1, primed<=1.
  - No record is produced.
- Valid sample with state==prev: dwell<=dwell+1, saturating at 2^CNT_W-1 (no wrap).
- Valid sample with state!=prev:
  - Form record {prev, state, dwell}.
  - prev<=state, dwell<=1.
  - The dwell in the record is the number of valid cycles the old state was held.
- Illegal value (state >= NUM_STATES): illegal_seen<=1.
  - The value is otherwise processed as a normal state: it is recorded and compared.
  - With NUM_STATES=4, illegal_seen never sets.
- FIFO behaviour:
  - Push when a record is formed. Pop when rec_valid && rec_ready.
  - rec_valid = (fill != 0). rec_data is the head entry, driven from registered storage.
  - Latency: a record formed at edge N is visible with rec_valid=1 after edge N, i.e. in cycle N+1.
  - Full and push with simultaneous pop: the push is accepted and fill is unchanged.
  - Full and push without pop: the record is dropped, overflow<=1, drop_count increments (saturating at 255). FIFO contents are unchanged.
  - Empty and push: the pop is ignored (rec_valid=0); the new record is seen the next cycle.
  - Push and pop on a non-full, non-empty FIFO: fill is unchanged.
  - Pointers wrap modulo DEPTH.
- rec_data must hold stable while rec_valid=1 and rec_ready=0.
- Sticky flags (illegal_seen, overflow) and drop_count clear only via rst.
- Reset mid-stream:
  - Pending records are lost.
  - The next valid sample re-primes; no spurious record is produced against the pre-reset prev.

Test Plan:
1. Reset, then a valid sequence A,A,A,B,B,C with rec_ready=1 -> records {A,B,3} then {B,C,2}. rec_data = 0x0103 then 0x0602. Each record appears the cycle after its change sample.
2. Hold A with state_valid=1 for 300 cycles, then B (CNT_W=8) -> one record {A,B,255} (saturated). Toggle state_valid low mid-hold -> those cycles are not counted.
3. rec_ready=0, then 6 alternating changes A,B,A,B,A,B,A (DEPTH=4) -> fill=4; overflow=1; drop_count=2. Draining yields the first 4 records in order, and rec_data is stable while stalled.
4. FIFO full and a change occurs with rec_ready=1 in the same cycle -> no drop, fill stays 4, overflow stays 0.
5. NUM_STATES=3, drive value 3 once -> illegal_seen=1 (sticky); records {x,3,n} and {3,y,1} are still produced.
6. Assert rst with 2 records queued, then drive C,D -> fill=0 after reset. The first post-reset C produces no record; then exactly {C,D,1}.
